// File: rtl/tanh_lut_loader.sv
// Loadable segment table for the piecewise-linear activation path.
// Entries stream in over valid/ready, then registered (base, next) pairs are served.
module tanh_lut_loader #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     load_start,
    input  logic                     wr_valid,
    input  logic signed [DATA_W-1:0] wr_data,
    output logic                     wr_ready,
    output logic                     busy,
    output logic                     load_done,
    output logic                     table_valid,
    input  logic [ADDR_W-1:0]        rd_address,
    output logic signed [DATA_W-1:0] rd_base,
    output logic signed [DATA_W-1:0] rd_next_data
);

    localparam int unsigned TBL_N = 2**ADDR_W + 1;
    localparam logic [ADDR_W:0] LAST_IDX = (ADDR_W+1)'(2**ADDR_W);

    typedef enum logic [1:0] {IDLE, LOAD, DONE} state_t;

    state_t                    r_state;
    state_t                    w_next_state;
    logic [ADDR_W:0]           r_cnt;
    logic                      r_table_valid;
    logic signed [DATA_W-1:0]  r_table [0:TBL_N-1];
    logic signed [DATA_W-1:0]  r_rd_base;
    logic signed [DATA_W-1:0]  r_rd_next;
    logic                      w_restart;
    logic                      w_write;
    logic                      w_last;
    logic [ADDR_W:0]           w_base_idx;
    logic [ADDR_W:0]           w_next_idx;

    // load_start is honoured in IDLE and LOAD only; a coinciding write is dropped
    assign w_restart  = load_start && (r_state != DONE);
    assign w_write    = wr_valid && wr_ready && !load_start;
    assign w_last     = (r_cnt == LAST_IDX);
    assign w_base_idx = {1'b0, rd_address};
    assign w_next_idx = w_base_idx + (ADDR_W+1)'(1);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= IDLE;
        else      r_state <= w_next_state;
    end

    always_comb begin
        w_next_state = r_state;
        case (r_state)
            IDLE: if (load_start) w_next_state = LOAD;
            LOAD: if (!load_start && w_write && w_last) w_next_state = DONE;
            DONE: w_next_state = IDLE;
            default: w_next_state = IDLE;
        endcase
    end

    always_comb begin
        wr_ready  = 1'b0;
        busy      = 1'b0;
        load_done = 1'b0;
        case (r_state)
            LOAD: begin
                wr_ready = 1'b1;
                busy     = 1'b1;
            end
            DONE: load_done = 1'b1;
            default: ;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_cnt         <= '0;
            r_table_valid <= 1'b0;
        end else if (w_restart) begin
            r_cnt         <= '0;
            r_table_valid <= 1'b0;
        end else if (w_write) begin
            r_cnt <= r_cnt + (ADDR_W+1)'(1);
            if (w_last) r_table_valid <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int unsigned i = 0; i < TBL_N; i++) r_table[i] <= '0;
        end else if (w_write) begin
            r_table[r_cnt] <= wr_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_rd_base <= '0;
            r_rd_next <= '0;
        end else if (r_table_valid) begin
            r_rd_base <= r_table[w_base_idx];
            r_rd_next <= r_table[w_next_idx];
        end else begin
            r_rd_base <= '0;
            r_rd_next <= '0;
        end
    end

    assign table_valid  = r_table_valid;
    assign rd_base      = r_rd_base;
    assign rd_next_data = r_rd_next;

endmodule
